// File: rtl/iu_mul_pkg.sv
// Shared definitions for the IU sequential multiplier: opcodes, FSM states, flag bit positions.
package iu_mul_pkg;

  localparam logic [5:0] OP_UMUL   = 6'b001010;
  localparam logic [5:0] OP_SMUL   = 6'b001011;
  localparam logic [5:0] OP_UMULCC = 6'b011010;
  localparam logic [5:0] OP_SMULCC = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/iu_mul_step.sv
// One shift-add step: adds mcand times the low BPC bits of the accumulator to its upper half,
// then shifts the whole accumulator right by BPC.
module iu_mul_step
  import iu_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH+BPC-1:0] partial;
  logic [WIDTH+BPC-1:0] sum;

  // The partial sum is WIDTH+BPC bits wide so the carry out of the upper half is kept.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BPC; j++) begin
      if (acc_in[j]) partial = partial + ({{BPC{1'b0}}, mcand} << j);
    end
    sum     = {{BPC{1'b0}}, acc_in[2*WIDTH-1:WIDTH]} + partial;
    acc_out = {sum, acc_in[WIDTH-1:BPC]};
  end

endmodule

// File: rtl/iu_seq_multiplier.sv
// Multi-cycle UMUL/SMUL/UMULcc/SMULcc unit: sign-magnitude shift-add core with a
// start/done handshake, registered rd/Yreg and icc flags.
module iu_seq_multiplier
  import iu_mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] Yreg,
  output logic [3:0]       flags,
  output logic             cc_we
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e         state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   mcand, mag_a, mag_b;
  logic               negate, is_cc, is_illegal;
  logic               legal_op, signed_op, cc_op;

  always_comb begin
    legal_op  = (op == OP_UMUL) || (op == OP_SMUL) || (op == OP_UMULCC) || (op == OP_SMULCC);
    signed_op = (op == OP_SMUL) || (op == OP_SMULCC);
    cc_op     = (op == OP_UMULCC) || (op == OP_SMULCC);
    // Most negative value negates to itself, which is its correct unsigned magnitude.
    mag_a     = (signed_op && A[WIDTH-1]) ? -A : A;
    mag_b     = (signed_op && B[WIDTH-1]) ? -B : B;
    prod_fix  = negate ? -acc : acc;
  end

  iu_mul_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_step (
    .acc_in  (acc),
    .mcand   (mcand),
    .acc_out (acc_step)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = legal_op ? CALC : DONE;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == CALC) || (state == FIX);
    done    = (state == DONE);
    illegal = done && is_illegal;
    cc_we   = done && is_cc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      negate     <= 1'b0;
      is_cc      <= 1'b0;
      is_illegal <= 1'b0;
      rd         <= '0;
      Yreg       <= '0;
      flags      <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc        <= {{WIDTH{1'b0}}, mag_a};
            mcand      <= mag_b;
            negate     <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            is_cc      <= cc_op;
            is_illegal <= !legal_op;
            cnt        <= CW'(N - 1);
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        // Results land at the FIX->DONE edge so they are visible while done is high.
        FIX: begin
          rd   <= prod_fix[WIDTH-1:0];
          Yreg <= prod_fix[2*WIDTH-1:WIDTH];
          if (is_cc) begin
            flags[FLAG_N] <= prod_fix[WIDTH-1];
            flags[FLAG_Z] <= (prod_fix[WIDTH-1:0] == '0);
            flags[FLAG_V] <= 1'b0;
            flags[FLAG_C] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
